// File: rtl/booth_r4_seq_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : booth_r4_seq_mul (with BoothPPG_32R4_NORM)                       |
// | Purpose  : iterative 32x32 radix-4 Booth multiplier, one group per cycle.   |
// | Options  : BOOTH_SEQ_EARLY_TERM_EN - stop once the remaining multiplier     |
// |            window is all 0s or all 1s                                       |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

module BoothPPG_32R4_NORM (
  input  logic [31:0] i_mulcand,
  input  logic        i_sign,
  input  logic [2:0]  i_r4input,
  output logic [33:0] o_pp
);
  logic [33:0] w_x34;
  logic [33:0] w_mag;

  assign w_x34 = {{2{i_sign & i_mulcand[31]}}, i_mulcand};

  // Negative digits are emitted as one's complement; the consumer adds the +1.
  always_comb begin
    w_mag = '0;
    case (i_r4input)
      3'b001, 3'b010, 3'b101, 3'b110: w_mag = w_x34;
      3'b011, 3'b100:                 w_mag = {w_x34[32:0], 1'b0};
      default:                        w_mag = '0;
    endcase
    o_pp = i_r4input[2] ? ~w_mag : w_mag;
  end
endmodule

module booth_r4_seq_mul #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [31:0]      in_mulcand,
  input  logic [31:0]      in_mulplier,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_product,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_x;
  logic               r_sign;
  logic [34:0]        r_yext;
  logic [4:0]         r_g;
  logic [65:0]        r_acc;
  logic [TAG_W-1:0]   r_tag;
  logic [63:0]        r_prod;
  logic [TAG_W-1:0]   r_otag;

  logic [2:0]         w_group;
  logic [33:0]        w_pp;
  logic [65:0]        w_term;
  logic [65:0]        w_add;
  logic [65:0]        w_acc_next;
  logic               w_early;
  logic               w_last;

  // r_yext shifts right two bits per cycle, so the current group is always [2:0].
  assign w_group = r_yext[2:0];

  BoothPPG_32R4_NORM u_ppg (
    .i_mulcand (r_x),
    .i_sign    (r_sign),
    .i_r4input (w_group),
    .o_pp      (w_pp)
  );

  assign w_term     = {{32{w_pp[33]}}, w_pp} + {65'd0, w_group[2]};
  assign w_add      = w_term << {r_g, 1'b0};
  assign w_acc_next = r_acc + w_add;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  // Window left for the next group is uniform: every remaining digit is zero.
  assign w_early = (r_yext[34:2] == 33'd0) || (&r_yext[34:2]);
`else
  assign w_early = 1'b0;
`endif

  assign w_last = (r_g == 5'd16) || w_early;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_sign <= 1'b0;
      r_yext <= '0;
      r_g    <= '0;
      r_acc  <= '0;
      r_tag  <= '0;
      r_prod <= '0;
      r_otag <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x    <= in_mulcand;
            r_sign <= in_sign;
            r_yext <= {{2{in_sign & in_mulplier[31]}}, in_mulplier, 1'b0};
            r_g    <= '0;
            r_acc  <= '0;
            r_tag  <= in_tag;
          end
        end
        S_RUN: begin
          r_acc  <= w_acc_next;
          r_yext <= {{2{r_yext[34]}}, r_yext[34:2]};
          r_g    <= r_g + 5'd1;
          if (w_last) begin
            r_prod <= w_acc_next[63:0];
            r_otag <= r_tag;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN);
  assign out_valid   = (r_state == S_DONE);
  assign out_product = r_prod;
  assign out_tag     = r_otag;
endmodule
`default_nettype wire

// File: tb/tb_booth_r4_seq_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_booth_r4_seq_mul                                              |
// | Purpose  : self-checking bench for booth_r4_seq_mul (directed + random).    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_booth_r4_seq_mul;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [31:0] in_mulcand;
  logic [31:0] in_mulplier;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic [3:0]  out_tag;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Operands presented while the current op is in flight (back-to-back test).
  bit          nxt_s;
  logic [31:0] nxt_x, nxt_y;
  logic [3:0]  nxt_t;

  booth_r4_seq_mul #(.TAG_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_mulcand  (in_mulcand),
    .in_mulplier (in_mulplier),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  function automatic int exp_lat(input bit s, input logic [31:0] y);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    longint unsigned yx, rem, ones;
    yx = {29'd0, s & y[31], s & y[31], y, 1'b0};
    for (int n = 1; n < 17; n++) begin
      rem  = yx >> (2 * n);
      ones = (64'd1 << (35 - 2 * n)) - 64'd1;
      if (rem == 0 || rem == ones) return n;
    end
    return 17;
`else
    return (s | ~s) ? 17 : 17;
`endif
  endfunction

  task automatic do_op(input bit s, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] t, input logic [63:0] exp, input int hold,
                       input bit keep, input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_mulcand = x; in_mulplier = y; in_tag = t;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk({nm, "_accept_timeout"}, 64'(n), 64'd0);
    @(posedge clk); #1;
    if (keep) begin
      in_sign = nxt_s; in_mulcand = nxt_x; in_mulplier = nxt_y; in_tag = nxt_t;
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat(s, y)));
    chk({nm, "_prod"}, out_product, exp);
    chk({nm, "_tag"}, 64'(out_tag), 64'(t));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_hold_prod"}, out_product, exp);
      chk({nm, "_hold_tag"}, 64'(out_tag), 64'(t));
      chk({nm, "_hold_inready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({nm, "_hs_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_hs_prod_kept"}, out_product, exp);
    chk({nm, "_hs_inready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    bit          s;
    logic [31:0] x, y;
    logic [3:0]  t;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_mulcand = '0; in_mulplier = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_prod", out_product, 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_inready", 64'(in_ready), 64'd1);

    do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hA, 64'h0000000000000001, 0, 1'b0, "s_m1m1");
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h3, 64'hFFFFFFFE00000001, 0, 1'b0, "u_max");
    do_op(1'b0, 32'hDEADBEEF, 32'h00000001, 4'h5, 64'h00000000DEADBEEF, 0, 1'b0, "u_dead");
    do_op(1'b1, 32'hDEADBEEF, 32'h00000001, 4'h6, 64'hFFFFFFFFDEADBEEF, 0, 1'b0, "s_dead");
    do_op(1'b1, 32'h80000000, 32'h7FFFFFFF, 4'h7, 64'hC000000080000000, 0, 1'b0, "s_minmax");
    do_op(1'b1, 32'h80000000, 32'h80000000, 4'h8, 64'h4000000000000000, 0, 1'b0, "s_minmin");
    do_op(1'b0, 32'h80000000, 32'h80000000, 4'h9, 64'h4000000000000000, 0, 1'b0, "u_minmin");
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    do_op(1'b0, 32'h12345678, 32'h00000001, 4'h1, 64'h0000000012345678, 0, 1'b0, "et_y1");
    do_op(1'b1, 32'h00000007, 32'hFFFFFFFF, 4'h2, 64'hFFFFFFFFFFFFFFF9, 0, 1'b0, "et_m1");
    do_op(1'b0, 32'h00000003, 32'h40000000, 4'h4, 64'h00000000C0000000, 0, 1'b0, "et_b30");
`endif

    // Backpressure plus a request held high through RUN and DONE.
    nxt_s = 1'b0; nxt_x = 32'd11; nxt_y = 32'd13; nxt_t = 4'hE;
    do_op(1'b0, 32'h0001_0001, 32'h0000_FFFF, 4'hC, 64'h0000_0000_FFFF_FFFF, 5, 1'b1, "bp");
    do_op(1'b0, 32'd11, 32'd13, 4'hE, 64'd143, 0, 1'b0, "b2b");

    // Reset while running around group 8 discards the operation.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_mulcand = 32'h1234; in_mulplier = 32'hFFFF0000; in_tag = 4'hF;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("mid_busy", 64'(busy), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_inready", 64'(in_ready), 64'd1);
    chk("mid_rst_prod", out_product, 64'd0);
    do_op(1'b0, 32'd3, 32'd5, 4'h2, 64'd15, 0, 1'b0, "after_rst");

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 500; i++) begin
        s = (m == 1);
        x = $urandom;
        y = $urandom;
        if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) y = ~y;
        t = 4'($urandom);
        do_op(s, x, y, t, ref_prod(s, x, y), 0, 1'b0, s ? "rnd_s" : "rnd_u");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
